// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results and control for the MEM stage,
// with stall/flush, natural-alignment fault capture and saturating load/store counters.
module ex_mem_reg #(
    parameter int unsigned NB_WIDTH = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_CNT   = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_WIDTH-1:0] i_alu_result,
    input  logic [NB_WIDTH-1:0] i_rt_data,
    input  logic [NB_REG-1:0]   i_rd_addr,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_BHW,
    input  logic                i_reg_write,
    input  logic                i_mem_to_reg,
    input  logic                i_halt,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_exc_clear,
    output logic                o_valid,
    output logic [NB_WIDTH-1:0] o_mem_addr,
    output logic [NB_WIDTH-1:0] o_mem_data,
    output logic                o_mem_read_CU,
    output logic                o_mem_write_CU,
    output logic [2:0]          o_BHW_CU,
    output logic [NB_REG-1:0]   o_rd_addr,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic                o_halt,
    output logic                o_misalign,
    output logic [NB_WIDTH-1:0] o_bad_addr,
    output logic [NB_CNT-1:0]   o_load_count,
    output logic [NB_CNT-1:0]   o_store_count
);

    logic addr_bad;
    logic misaligned;
    logic take;
    logic capture;
    logic load_inc;
    logic store_inc;

    // Alignment check and qualification of the instruction being captured
    always_comb begin
        addr_bad = 1'b0;
        case (i_BHW[1:0])
            2'b00:   addr_bad = 1'b0;
            2'b01:   addr_bad = i_alu_result[0];
            default: addr_bad = |i_alu_result[1:0];
        endcase
        misaligned = i_valid & (i_mem_read | i_mem_write) & addr_bad;
        take       = i_valid & ~misaligned;
        capture    = ~i_stall & ~i_flush;
        load_inc   = capture & take & i_mem_read  & (o_load_count  != '1);
        store_inc  = capture & take & i_mem_write & (o_store_count != '1);
    end

    // Pipeline payload and control
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_valid        <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_data     <= '0;
            o_mem_read_CU  <= 1'b0;
            o_mem_write_CU <= 1'b0;
            o_BHW_CU       <= 3'b000;
            o_rd_addr      <= '0;
            o_reg_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_halt         <= 1'b0;
        end else if (i_flush) begin
            o_valid        <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_data     <= '0;
            o_mem_read_CU  <= 1'b0;
            o_mem_write_CU <= 1'b0;
            o_BHW_CU       <= 3'b000;
            o_rd_addr      <= '0;
            o_reg_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_halt         <= 1'b0;
        end else if (!i_stall) begin
            o_valid        <= take;
            o_mem_addr     <= i_alu_result;
            o_mem_data     <= i_rt_data;
            o_mem_read_CU  <= take & i_mem_read;
            o_mem_write_CU <= take & i_mem_write;
            o_BHW_CU       <= i_BHW;
            o_rd_addr      <= i_rd_addr;
            o_reg_write    <= take & i_reg_write;
            o_mem_to_reg   <= i_valid & i_mem_to_reg;
            o_halt         <= take & i_halt;
        end
    end

    // Sticky fault: a new fault beats a coincident clear and reloads the address
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_misalign <= 1'b0;
            o_bad_addr <= '0;
        end else if (!i_stall) begin
            if (!i_flush && misaligned) begin
                o_misalign <= 1'b1;
                if (!o_misalign || i_exc_clear) begin
                    o_bad_addr <= i_alu_result;
                end
            end else if (i_exc_clear) begin
                o_misalign <= 1'b0;
            end
        end
    end

    // Saturating debug counters, cleared only by reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_load_count  <= '0;
            o_store_count <= '0;
        end else begin
            if (load_inc) begin
                o_load_count <= o_load_count + NB_CNT'(1);
            end
            if (store_inc) begin
                o_store_count <= o_store_count + NB_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg with a narrow counter to reach saturation quickly.
module tb_ex_mem_reg;

    localparam int unsigned NW = 32;
    localparam int unsigned NR = 5;
    localparam int unsigned NC = 4;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [NW-1:0] i_alu_result = '0;
    logic [NW-1:0] i_rt_data = '0;
    logic [NR-1:0] i_rd_addr = '0;
    logic          i_mem_read = 1'b0;
    logic          i_mem_write = 1'b0;
    logic [2:0]    i_BHW = 3'b000;
    logic          i_reg_write = 1'b0;
    logic          i_mem_to_reg = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_exc_clear = 1'b0;
    logic          o_valid;
    logic [NW-1:0] o_mem_addr;
    logic [NW-1:0] o_mem_data;
    logic          o_mem_read_CU;
    logic          o_mem_write_CU;
    logic [2:0]    o_BHW_CU;
    logic [NR-1:0] o_rd_addr;
    logic          o_reg_write;
    logic          o_mem_to_reg;
    logic          o_halt;
    logic          o_misalign;
    logic [NW-1:0] o_bad_addr;
    logic [NC-1:0] o_load_count;
    logic [NC-1:0] o_store_count;

    always #5 i_clk = ~i_clk;

    ex_mem_reg #(.NB_WIDTH(NW), .NB_REG(NR), .NB_CNT(NC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
        .i_alu_result(i_alu_result), .i_rt_data(i_rt_data), .i_rd_addr(i_rd_addr),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_BHW(i_BHW),
        .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_halt(i_halt),
        .i_stall(i_stall), .i_flush(i_flush), .i_exc_clear(i_exc_clear),
        .o_valid(o_valid), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_mem_read_CU(o_mem_read_CU), .o_mem_write_CU(o_mem_write_CU),
        .o_BHW_CU(o_BHW_CU), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_mem_to_reg(o_mem_to_reg), .o_halt(o_halt), .o_misalign(o_misalign),
        .o_bad_addr(o_bad_addr), .o_load_count(o_load_count), .o_store_count(o_store_count)
    );

    typedef struct packed {
        logic          valid;
        logic [NW-1:0] addr;
        logic [NW-1:0] data;
        logic          rd_en;
        logic          wr_en;
        logic [2:0]    bhw;
        logic [NR-1:0] rd;
        logic          reg_write;
        logic          mem_to_reg;
        logic          halt;
        logic          misalign;
        logic [NW-1:0] bad_addr;
        logic [NC-1:0] ld;
        logic [NC-1:0] st;
    } obs_t;

    obs_t e, got, want;
    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic obs_t observe();
        obs_t o;
        o.valid      = o_valid;
        o.addr       = o_mem_addr;
        o.data       = o_mem_data;
        o.rd_en      = o_mem_read_CU;
        o.wr_en      = o_mem_write_CU;
        o.bhw        = o_BHW_CU;
        o.rd         = o_rd_addr;
        o.reg_write  = o_reg_write;
        o.mem_to_reg = o_mem_to_reg;
        o.halt       = o_halt;
        o.misalign   = o_misalign;
        o.bad_addr   = o_bad_addr;
        o.ld         = o_load_count;
        o.st         = o_store_count;
        return o;
    endfunction

    // Expected pipeline fields on top of the current fault/counter expectation
    function automatic obs_t fields(input obs_t b, input logic v, input logic [NW-1:0] a,
                                    input logic [NW-1:0] d, input logic rdn, input logic wrn,
                                    input logic [2:0] bhw, input logic [NR-1:0] rd,
                                    input logic rw, input logic m2r, input logic h);
        obs_t o = b;
        o.valid = v; o.addr = a; o.data = d; o.rd_en = rdn; o.wr_en = wrn;
        o.bhw = bhw; o.rd = rd; o.reg_write = rw; o.mem_to_reg = m2r; o.halt = h;
        return o;
    endfunction

    task automatic drive(input logic v, input logic [NW-1:0] a, input logic [NW-1:0] d,
                         input logic rdn, input logic wrn, input logic [2:0] bhw,
                         input logic [NR-1:0] rd, input logic rw, input logic m2r,
                         input logic h);
        i_valid = v; i_alu_result = a; i_rt_data = d; i_mem_read = rdn;
        i_mem_write = wrn; i_BHW = bhw; i_rd_addr = rd; i_reg_write = rw;
        i_mem_to_reg = m2r; i_halt = h;
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        i_stall = 1'b0; i_flush = 1'b0; i_exc_clear = 1'b0;
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        e = '0;
    endtask

    task automatic test_reset();
        #2 i_reset = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_init got=%h want=0", got);
        end
        do_reset();
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", got, want);
        end
    endtask

    task automatic test_capture();
        drive(1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b1, 3'b011, 5'd3, 1'b0, 1'b0, 1'b0);
        e = fields(e, 1'b1, 32'h10, 32'h1234_5678, 1'b0, 1'b1, 3'b011, 5'd3, 1'b0, 1'b0, 1'b0);
        e.st = 4'd1;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL capture_store got=%h want=%h", got, want);
        end
        #2 i_reset = 1'b0;
        #1;
        got = observe(); checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", got);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        e = '0;
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h20, 32'hAAAA, 1'b1, 1'b0, 3'b011, 5'd5, 1'b1, 1'b1, 1'b0);
        e = fields(e, 1'b1, 32'h20, 32'hAAAA, 1'b1, 1'b0, 3'b011, 5'd5, 1'b1, 1'b1, 1'b0);
        e.ld = 4'd1;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL load_capture got=%h want=%h", got, want);
        end
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40 + NW'(i), 32'hBEEF, 1'b1, 1'b1, 3'b011, 5'd9, 1'b1, 1'b0, 1'b1);
            sb.push_back(e);
            cycle();
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h want=%h", i, got, want);
            end
        end
        i_flush = 1'b1;
        e = fields(e, 1'b0, '0, '0, 1'b0, 1'b0, 3'b000, '0, 1'b0, 1'b0, 1'b0);
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL stall_flush got=%h want=%h", got, want);
        end
        i_stall = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic test_alignment();
        drive(1'b1, 32'h11, 32'h55, 1'b1, 1'b0, 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
        e = fields(e, 1'b0, 32'h11, 32'h55, 1'b0, 1'b0, 3'b001, 5'd7, 1'b0, 1'b0, 1'b0);
        e.misalign = 1'b1; e.bad_addr = 32'h11;
        sb.push_back(e);
        drive(1'b1, 32'h11, 32'h66, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0);
        e = fields(e, 1'b1, 32'h11, 32'h66, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0);
        e.ld = 4'd2;
        sb.push_back(e);
        drive(1'b1, 32'h12, 32'h77, 1'b1, 1'b0, 3'b011, 5'd7, 1'b1, 1'b0, 1'b0);
        e = fields(e, 1'b0, 32'h12, 32'h77, 1'b0, 1'b0, 3'b011, 5'd7, 1'b0, 1'b0, 1'b0);
        sb.push_back(e);
        // Re-drive the first two stimuli so each queued expectation meets its own edge
        drive(1'b1, 32'h11, 32'h55, 1'b1, 1'b0, 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL align[%0d] got=%h want=%h", i, got, want);
            end
            if (i == 0) drive(1'b1, 32'h11, 32'h66, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0);
            if (i == 1) drive(1'b1, 32'h12, 32'h77, 1'b1, 1'b0, 3'b011, 5'd7, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_clear();
        i_exc_clear = 1'b1;
        drive(1'b1, 32'h06, 32'h88, 1'b1, 1'b0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0);
        e = fields(e, 1'b0, 32'h06, 32'h88, 1'b0, 1'b0, 3'b011, 5'd8, 1'b0, 1'b0, 1'b0);
        e.misalign = 1'b1; e.bad_addr = 32'h06;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL clear_collide got=%h want=%h", got, want);
        end
        drive(1'b0, 32'h30, 32'h99, 1'b0, 1'b0, 3'b011, 5'd9, 1'b0, 1'b0, 1'b0);
        e = fields(e, 1'b0, 32'h30, 32'h99, 1'b0, 1'b0, 3'b011, 5'd9, 1'b0, 1'b0, 1'b0);
        e.misalign = 1'b0;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL clear_alone got=%h want=%h", got, want);
        end
        i_exc_clear = 1'b0;
    endtask

    task automatic test_reserved();
        drive(1'b1, 32'h04, 32'h0A, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0);
        e = fields(e, 1'b1, 32'h04, 32'h0A, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0);
        e.ld = 4'd3;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reserved_ok got=%h want=%h", got, want);
        end
        drive(1'b1, 32'h02, 32'h0B, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 1'b0, 1'b0);
        e = fields(e, 1'b0, 32'h02, 32'h0B, 1'b0, 1'b0, 3'b010, 5'd10, 1'b0, 1'b0, 1'b0);
        e.misalign = 1'b1; e.bad_addr = 32'h02;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reserved_fault got=%h want=%h", got, want);
        end
    endtask

    task automatic test_halt_and_stalled_clear();
        drive(1'b1, 32'h50, 32'h0, 1'b0, 1'b0, 3'b011, 5'd0, 1'b0, 1'b0, 1'b1);
        e = fields(e, 1'b1, 32'h50, 32'h0, 1'b0, 1'b0, 3'b011, 5'd0, 1'b0, 1'b0, 1'b1);
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL halt_pass got=%h want=%h", got, want);
        end
        i_stall = 1'b1;
        i_exc_clear = 1'b1;
        drive(1'b0, 32'h54, 32'h1, 1'b0, 1'b0, 3'b011, 5'd0, 1'b0, 1'b0, 1'b1);
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL stalled_clear got=%h want=%h", got, want);
        end
        i_stall = 1'b0;
        i_exc_clear = 1'b0;
        e = fields(e, 1'b0, 32'h54, 32'h1, 1'b0, 1'b0, 3'b011, 5'd0, 1'b0, 1'b0, 1'b0);
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL halt_bubble got=%h want=%h", got, want);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + NW'(4 * i), NW'(i), 1'b0, 1'b1, 3'b011, 5'd0, 1'b0, 1'b0, 1'b0);
            e = fields(e, 1'b1, 32'h100 + NW'(4 * i), NW'(i), 1'b0, 1'b1, 3'b011, 5'd0,
                       1'b0, 1'b0, 1'b0);
            e.st = (e.st == 4'hF) ? 4'hF : e.st + 4'd1;
            sb.push_back(e);
            cycle();
            got = observe(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sat_store[%0d] got=%h want=%h", i, got, want);
            end
        end
        drive(1'b1, 32'h200, 32'h5, 1'b1, 1'b1, 3'b011, 5'd1, 1'b1, 1'b1, 1'b0);
        e = fields(e, 1'b1, 32'h200, 32'h5, 1'b1, 1'b1, 3'b011, 5'd1, 1'b1, 1'b1, 1'b0);
        e.ld = 4'd1; e.st = 4'hF;
        sb.push_back(e);
        cycle();
        got = observe(); want = sb.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL both_rw got=%h want=%h", got, want);
        end
    endtask

    initial begin
        e = '0;
        test_reset();
        test_capture();
        test_stall_flush();
        test_alignment();
        test_clear();
        test_reserved();
        test_halt_and_stalled_clear();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
